// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-time programmable serial sequence detector with hit target and timeout
module seq_detect_ctrl #(
  parameter  int PATTERN_W = 6,
  parameter  int CNT_W     = 8,
  parameter  int TIMEOUT_W = 16,
  localparam int LEN_W     = $clog2(PATTERN_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [CNT_W-1:0]     cfg_target,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 a_valid,
  input  logic                 a,
  output logic                 detected,
  output logic [CNT_W-1:0]     hit_count,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, TIMEOUT} state_t;

  state_t               state, state_next;
  logic [PATTERN_W-1:0] hist, hist_next, pat_q, mask;
  logic [PATTERN_W:0]   mask_wide;
  logic [LEN_W-1:0]     len_q, bits_seen, bits_next;
  logic [CNT_W-1:0]     tgt_q, hits_next, eff_target;
  logic [TIMEOUT_W-1:0] to_q, timer;
  logic                 accept, sample, match;

  always_comb begin
    accept     = start && (cfg_len != '0) && (cfg_len <= LEN_W'(PATTERN_W));
    // A sample coinciding with an accepted start is discarded by the re-arm.
    sample     = (state == ARMED) && a_valid && !accept;
    hist_next  = {hist[PATTERN_W-2:0], a};
    bits_next  = (bits_seen == LEN_W'(PATTERN_W)) ? bits_seen : bits_seen + 1'b1;
    mask_wide  = ({{PATTERN_W{1'b0}}, 1'b1} << len_q) - 1'b1;
    mask       = mask_wide[PATTERN_W-1:0];
    match      = sample && (bits_next >= len_q) && (((hist_next ^ pat_q) & mask) == '0);
    hits_next  = (&hit_count) ? hit_count : hit_count + 1'b1;
    eff_target = (tgt_q == '0) ? CNT_W'(1) : tgt_q;

    state_next = state;
    if (accept) begin
      state_next = ARMED;
    end else if (state == ARMED) begin
      if (match && (hits_next >= eff_target)) begin
        state_next = DONE;
      end else if ((to_q != '0) && (timer == to_q - 1'b1)) begin
        state_next = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next == ARMED);
      done      <= (state_next == DONE);
      timed_out <= (state_next == TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      detected  <= 1'b0;
      hit_count <= '0;
      hist      <= '0;
      bits_seen <= '0;
      timer     <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      to_q      <= '0;
    end else begin
      detected <= match;
      if (accept) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        tgt_q     <= cfg_target;
        to_q      <= cfg_timeout;
        hist      <= '0;
        bits_seen <= '0;
        hit_count <= '0;
        timer     <= '0;
      end else if (state == ARMED) begin
        timer <= timer + 1'b1;
        if (sample) begin
          hist      <= hist_next;
          bits_seen <= bits_next;
        end
        if (match) begin
          hit_count <= hits_next;
        end
      end
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time programmable serial sequence-detection controller. It is armed with a pattern of 1..PATTERN_W bits, a target hit count and an optional timeout. It then watches a qualified serial bit stream, pulses on every overlapping match, counts hits, and finishes in DONE or TIMEOUT. It sits between the stream source and software/status logic, and replaces the fixed-pattern detectors where the pattern must change at run time.

Parameters:
PATTERN_W, 6, maximum pattern length in bits
CNT_W, 8, width of hit counter and target
TIMEOUT_W, 16, width of timeout counter
LEN_W, $clog2(PATTERN_W+1) (derived, localparam), width of cfg_len

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
start  in  1  arm request; latches cfg_* when accepted
cfg_pattern  in  PATTERN_W  pattern; bit cfg_len-1 is first bit received, bit 0 is last
cfg_len  in  LEN_W  pattern length, valid 1..PATTERN_W
cfg_target  in  CNT_W  hits required for DONE; 0 treated as 1
cfg_timeout  in  TIMEOUT_W  cycles allowed in ARMED; 0 = no timeout
a_valid  in  1  qualifies a; a is ignored when low
a  in  1  serial data bit
detected  out  1  one-cycle pulse per match
hit_count  out  CNT_W  matches since last accepted start
busy  out  1  high in ARMED
done  out  1  high in DONE
timed_out  out  1  high in TIMEOUT

Behaviour:
- Reset (rst=1 at posedge): state IDLE. Every output is 0. History, bit count, timer and latched config are cleared.
- Start acceptance:
  - start is accepted in any state when 1 <= cfg_len <= PATTERN_W. If cfg_len is invalid, start is ignored and the state is unchanged.
  - On acceptance: latch cfg_*, clear history, bits_seen, hit_count and timer, and go to ARMED.
  - start during ARMED aborts the current run and re-arms with the same clearing. No detected pulse is produced for a sample taken in that cycle.
- History is a PATTERN_W-bit shift register with the newest bit in the LSB.
  - It shifts only when a_valid=1.
  - bits_seen increments on each valid sample and saturates at PATTERN_W.
- Match (evaluated in ARMED on a valid sample, using the history including the new bit): bits_seen >= cfg_len AND the low cfg_len bits of history equal the low cfg_len bits of cfg_pattern.
  - Overlapping matches are allowed. History is not cleared on a match.
- Latency: detected is registered. It is high for exactly the cycle after the posedge that sampled the completing bit. hit_count updates on that same edge.
- hit_count saturates at all-ones. It never wraps.
- FSM:
  - IDLE: wait for accepted start.
  - ARMED: timer increments every clock, whether or not a_valid is high.
    - If a match brings hit_count to the effective target, go to DONE.
    - Otherwise, if cfg_timeout != 0 and timer == cfg_timeout-1, go to TIMEOUT.
  - DONE, TIMEOUT: hold status and hit_count. Ignore a. Leave only on accepted start or rst.
- Simultaneous match-to-target and timeout expiry in the same cycle: DONE wins, and detected pulses.
- a_valid=0 bubbles: no shift, no match, no detected. The timer still runs.
- Reset mid-run: rst overrides start and all other inputs; next cycle is IDLE with outputs 0.
- busy, done and timed_out are registered state decodes. Exactly one of them (or none, in IDLE) is high.

Test Plan:
- Run 1:
  - Stimulus: rst 2 cycles, then start with pattern=6'b110011, len=6, target=2, timeout=0. a_valid=1 and stream 0011_0101_1001_1001_1010_1000 (index 0 first).
  - Required response: detected pulses in the cycle after index 12 and after index 16. hit_count=2. done=1 from the cycle after index 16. Later matches are ignored.
- Run 2:
  - Stimulus: same stream with pattern=4'b1010 in bits[3:0], len=4, target=255.
  - Required response: pulses after indices 6, 19 and 21. hit_count=3. busy stays 1.
- Run 3:
  - Stimulus: pattern 4'b1111, len=4, target=1, timeout=10, a=0 constantly.
  - Required response: busy for 10 cycles after start, then timed_out=1, detected never pulses, hit_count=0.
- Run 4:
  - Stimulus: pattern 110011 with a_valid=0 for 3 cycles inserted between each bit of 110011.
  - Required response: exactly one detected pulse, in the cycle after the final valid 1. No pulses during bubbles.
- Run 5:
  - Stimulus: in ARMED after 11001, assert start with new pattern 2'b01, len=2. Then send 1, 0, 1.
  - Required response: no match on the stale 11001 history. One pulse after the final 1 (01 completes). Also assert start with len=0 in DONE: state stays DONE.
- Run 6:
  - Stimulus: assert rst for one cycle while ARMED with hit_count=1.
  - Required response: next cycle busy=0, hit_count=0 and detected=0. A match on the next input is ignored until a new start is accepted.
